// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI read constants, default widths and the burst-read FSM state type.
package axi_pkg;
  localparam int ID_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int LEN_W = 7;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_2B = 3'b001;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} rd_state_t;
endpackage

// File: rtl/axi_burst_read_master.sv
// axi_burst_read_master: issues one INCR read burst per core request and streams R beats to a fill port.
module axi_burst_read_master
  import axi_pkg::*;
#(
  parameter int ID_WIDTH = ID_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int LEN_WIDTH = LEN_W,
  parameter logic [ID_WIDTH-1:0] MASTER_ID = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  busy,
  output logic                  fill_valid,
  output logic [LEN_WIDTH-1:0]  fill_idx,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   arid_m_inf,
  output logic [ADDR_WIDTH-1:0] araddr_m_inf,
  output logic [LEN_WIDTH-1:0]  arlen_m_inf,
  output logic [2:0]            arsize_m_inf,
  output logic [1:0]            arburst_m_inf,
  output logic                  arvalid_m_inf,
  input  logic                  arready_m_inf,
  input  logic [ID_WIDTH-1:0]   rid_m_inf,
  input  logic [DATA_WIDTH-1:0] rdata_m_inf,
  input  logic [1:0]            rresp_m_inf,
  input  logic                  rlast_m_inf,
  input  logic                  rvalid_m_inf,
  output logic                  rready_m_inf
);
  rd_state_t state, state_nx;
  logic [LEN_WIDTH-1:0] cnt;
  logic beat, at_len;
  assign arid_m_inf = MASTER_ID;
  assign arsize_m_inf = AXI_SIZE_2B;
  assign arburst_m_inf = AXI_BURST_INCR;
  assign beat = state == DATA && rvalid_m_inf;
  assign at_len = cnt == arlen_m_inf;
  always_comb begin
    state_nx = state;
    req_ready = state == IDLE;
    busy = state != IDLE;
    arvalid_m_inf = state == ADDR;
    rready_m_inf = state == DATA;
    if (state == IDLE && req_valid) state_nx = ADDR;
    if (state == ADDR && arready_m_inf) state_nx = DATA;
    if (beat && (rlast_m_inf || at_len)) state_nx = FIN;
    if (state == FIN && done) state_nx = IDLE;
  end
  // done is held off one FIN cycle so it trails the final fill beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      araddr_m_inf <= '0;
      arlen_m_inf <= '0;
      cnt <= '0;
      err <= 1'b0;
      fill_valid <= 1'b0;
      fill_idx <= '0;
      fill_data <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      fill_valid <= beat;
      done <= state == FIN && !done;
      if (state == IDLE && req_valid) begin
        araddr_m_inf <= req_addr;
        arlen_m_inf <= req_len;
        cnt <= '0;
        err <= 1'b0;
      end
      if (beat) begin
        fill_idx <= cnt;
        fill_data <= rdata_m_inf;
        cnt <= at_len ? cnt : cnt + 1'b1;
        if (rresp_m_inf != AXI_RESP_OKAY || rid_m_inf != MASTER_ID || rlast_m_inf != at_len) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_burst_read_master.sv
// tb_axi_burst_read_master: randomized AXI slave stimulus checked against a spec-level burst model.
module tb_axi_burst_read_master;
  localparam int IW = 4, AW = 32, DW = 16, LW = 7;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, busy, fill_valid, done, err;
  logic [AW-1:0] req_addr = '0, araddr;
  logic [LW-1:0] req_len = '0, fill_idx, arlen;
  logic [DW-1:0] fill_data, rdata = '0;
  logic [IW-1:0] arid, rid = '0;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp = '0;
  logic arvalid, arready = 0, rlast = 0, rvalid = 0, rready;
  int tests = 0, fails = 0, cyc = 0;

  axi_burst_read_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .busy(busy), .fill_valid(fill_valid), .fill_idx(fill_idx),
    .fill_data(fill_data), .done(done), .err(err), .arid_m_inf(arid), .araddr_m_inf(araddr),
    .arlen_m_inf(arlen), .arsize_m_inf(arsize), .arburst_m_inf(arburst),
    .arvalid_m_inf(arvalid), .arready_m_inf(arready), .rid_m_inf(rid), .rdata_m_inf(rdata),
    .rresp_m_inf(rresp), .rlast_m_inf(rlast), .rvalid_m_inf(rvalid), .rready_m_inf(rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && req_valid && req_ready)
      assert (int'(req_addr[11:0]) + 2 * (int'(req_len) + 1) <= 4096)
      else $error("request crosses a 4 KB page");

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fill_valid"}, fill_valid, 0);
    chk({tag, "_fill_idx"}, fill_idx, 0);
    chk({tag, "_fill_data"}, fill_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_arlen"}, arlen, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_arid"}, arid, 0);
    chk({tag, "_arsize"}, arsize, 3'b001);
    chk({tag, "_arburst"}, arburst, 2'b01);
  endtask

  task automatic issue(input logic [AW-1:0] addr, input int len, input int ard);
    req_addr = addr;
    req_len = LW'(len);
    req_valid = 1;
    chk("req_ready", req_ready, 1);
    step();
    chk("busy_after_accept", busy, 1);
    chk("err_cleared", err, 0);
    req_addr = ~addr;
    req_len = ~LW'(len);
    for (int k = 0; k <= ard; k++) begin
      chk("req_ready_busy", req_ready, 0);
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, addr);
      chk("arlen", arlen, len);
      arready = k == ard;
      step();
    end
    arready = 0;
    req_valid = 0;
    chk("arvalid_drop", arvalid, 0);
  endtask

  // early/errb/badb < 0 disables that slave fault; data for beat b is dbase + b
  task automatic run_burst(input logic [AW-1:0] addr, input int len, input int ard, input int gap,
                           input int errb, input int early, input int badb, input logic [DW-1:0] dbase);
    int last = (early >= 0 && early < len) ? early : len;
    bit exp_err = (early >= 0 && early < len) || (errb >= 0 && errb <= last) || (badb >= 0 && badb <= last);
    int b = 0, nfill = 0, last_fill = -100, done_cyc = -1;
    bit fin = 0, hs;
    logic [DW-1:0] exp_d;
    issue(addr, len, ard);
    for (int t = 0; t < 4000 && !fin; t++) begin
      if (fill_valid) begin
        exp_d = dbase + DW'(nfill);
        chk("fill_idx", fill_idx, nfill);
        chk("fill_data", fill_data, exp_d);
        nfill++;
        last_fill = cyc;
      end
      if (done) begin
        fin = 1;
        done_cyc = cyc;
        chk("rready_at_done", rready, 0);
        chk("busy_at_done", busy, 1);
      end
      rvalid = !fin && b <= len && $urandom_range(99) >= gap;
      rdata = dbase + DW'(b);
      rlast = b == len || b == early;
      rresp = b == errb ? 2'b10 : 2'b00;
      rid = b == badb ? 4'd1 : 4'd0;
      hs = rvalid && rready;
      step();
      if (hs) b++;
    end
    rvalid = 0;
    chk("done_seen", fin, 1);
    chk("fill_count", nfill, last + 1);
    chk("done_after_last_fill", done_cyc - last_fill, 1);
    chk("err_at_done", err, exp_err);
    chk("done_pulse_once", done, 0);
    chk("busy_low", busy, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  task automatic reset_mid_data();
    int b = 0;
    issue(32'h0000_3000, 31, 0);
    for (int t = 0; t < 200 && b < 10; t++) begin
      rvalid = 1;
      rdata = DW'(b);
      rlast = 0;
      rresp = 0;
      rid = 0;
      step();
      b++;
    end
    chk("rready_before_rst", rready, 1);
    rdata = 16'd10;
    #2 rst = 1;
    #1 chk_reset_vals("async_rst");
    for (int t = 0; t < 3; t++) begin
      step();
      chk("no_done_in_rst", done, 0);
    end
    rvalid = 0;
    rst = 0;
    step();
    chk_reset_vals("post_rst");
  endtask

  initial begin
    int len, off;
    logic [AW-1:0] page;
    #2 chk_reset_vals("reset");
    step();
    step();
    rst = 0;
    step();
    chk_reset_vals("idle");
    run_burst(32'h0000_1000, 0, 0, 0, -1, -1, -1, 16'hBEEF);
    run_burst(32'h0000_2000, 127, 20, 40, -1, -1, -1, 16'h0000);
    run_burst(32'h0000_2100, 7, 1, 0, 3, -1, -1, 16'h1234);
    run_burst(32'h0000_2200, 7, 0, 10, -1, -1, -1, 16'h4321);
    run_burst(32'h0000_2300, 7, 2, 20, -1, 5, -1, 16'h5A00);
    run_burst(32'h0000_2400, 3, 0, 0, -1, -1, 2, 16'h7700);
    reset_mid_data();
    run_burst(32'h0000_3000, 15, 3, 30, -1, -1, -1, 16'hC0DE);
    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(0, 127);
      page = $urandom & 32'hFFFF_F000;
      off = 2 * $urandom_range(0, (4096 - 2 * (len + 1)) / 2);
      run_burst(page | AW'(off), len, $urandom_range(0, 5), $urandom_range(0, 60),
                $urandom_range(3) == 0 ? $urandom_range(0, len) : -1,
                $urandom_range(3) == 0 ? $urandom_range(0, len) : -1,
                $urandom_range(5) == 0 ? $urandom_range(0, len) : -1,
                DW'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
